// File: rtl/dac_frame_if.sv
// Handshake bundle between dac_frame_scheduler, its two sample sources and the SPI DAC driver.
// master = scheduler side; slave = sources plus driver side.
interface dac_frame_if #(
    parameter int DATA_W = 12
);
    logic [DATA_W-1:0] a_data;
    logic              a_valid;
    logic              a_ready;
    logic [DATA_W-1:0] b_data;
    logic              b_valid;
    logic              b_ready;
    logic              drv_go;
    logic              drv_sel;
    logic [DATA_W-1:0] drv_data;
    logic              drv_ready;

    modport master (
        input  a_data, a_valid, b_data, b_valid, drv_ready,
        output a_ready, b_ready, drv_go, drv_sel, drv_data
    );

    modport slave (
        output a_data, a_valid, b_data, b_valid, drv_ready,
        input  a_ready, b_ready, drv_go, drv_sel, drv_data
    );
endinterface

// File: rtl/dac_frame_scheduler.sv
// Fixed-rate frame sequencer: per tick captures one word from A and B, then drives the DAC driver A then B.
// Optional DAC_HOLD_LAST_EN: underrun fill repeats the channel's last word instead of mid-scale.
module dac_frame_scheduler #(
    parameter int CLK_DIV = 2500,
    parameter int DATA_W  = 12
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        clear_flags,
    dac_frame_if.master bus,
    output logic        busy,
    output logic [1:0]  underrun,
    output logic        overrun
);
    localparam logic [15:0] TC = 16'(CLK_DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_CAP, S_GO_A, S_WAIT_A, S_GO_B, S_WAIT_B
    } state_t;

    state_t              r_state, w_next;
    logic [15:0]         r_cnt;
    logic                r_tick;
    logic                w_tick;
    logic                r_a_ready, r_b_ready;
    logic [DATA_W-1:0]   r_shadow_a, r_shadow_b;
    logic [DATA_W-1:0]   w_fill_a, w_fill_b;
    logic [DATA_W-1:0]   w_cap_a, w_cap_b;
    logic                r_drv_go, w_go;
    logic                r_drv_sel, w_sel;
    logic [DATA_W-1:0]   r_drv_data, w_data;
    logic [1:0]          r_underrun, w_ur_set;
    logic                r_overrun;

    // Registered tick so the first one lands exactly CLK_DIV cycles after enable rises.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt  <= '0;
            r_tick <= 1'b0;
        end else if (!enable) begin
            r_cnt  <= '0;
            r_tick <= 1'b0;
        end else begin
            r_tick <= (r_cnt == TC);
            r_cnt  <= (r_cnt == TC) ? 16'd0 : r_cnt + 16'd1;
        end
    end

    assign w_tick = r_tick & enable;

`ifdef DAC_HOLD_LAST_EN
    assign w_fill_a = r_shadow_a;
    assign w_fill_b = r_shadow_b;
`else
    localparam logic [DATA_W-1:0] MID = {1'b1, {(DATA_W-1){1'b0}}};
    assign w_fill_a = MID;
    assign w_fill_b = MID;
`endif

    // Ready pulses are decided on the tick cycle, so in CAP they mark the words being taken.
    assign w_cap_a  = r_a_ready ? bus.a_data : w_fill_a;
    assign w_cap_b  = r_b_ready ? bus.b_data : w_fill_b;
    assign w_ur_set = (r_state == S_CAP) ? {~r_b_ready, ~r_a_ready} : 2'b00;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    // The go pulse is high exactly in the first WAIT cycle, so it doubles as the blanking marker.
    always_comb begin
        w_next = r_state;
        w_go   = 1'b0;
        w_sel  = r_drv_sel;
        w_data = r_drv_data;
        case (r_state)
            S_IDLE:   if (w_tick) w_next = S_CAP;
            S_CAP: begin
                if (bus.drv_ready) begin
                    w_next = S_WAIT_A;
                    w_go   = 1'b1;
                    w_sel  = 1'b0;
                    w_data = w_cap_a;
                end else begin
                    w_next = S_GO_A;
                end
            end
            S_GO_A: begin
                if (bus.drv_ready) begin
                    w_next = S_WAIT_A;
                    w_go   = 1'b1;
                    w_sel  = 1'b0;
                    w_data = r_shadow_a;
                end
            end
            S_WAIT_A: if (!r_drv_go && bus.drv_ready) w_next = S_GO_B;
            S_GO_B: begin
                if (bus.drv_ready) begin
                    w_next = S_WAIT_B;
                    w_go   = 1'b1;
                    w_sel  = 1'b1;
                    w_data = r_shadow_b;
                end
            end
            S_WAIT_B: if (!r_drv_go && bus.drv_ready) w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_drv_go   <= 1'b0;
            r_drv_sel  <= 1'b0;
            r_drv_data <= '0;
            r_a_ready  <= 1'b0;
            r_b_ready  <= 1'b0;
            r_shadow_a <= '0;
            r_shadow_b <= '0;
            r_underrun <= 2'b00;
            r_overrun  <= 1'b0;
        end else begin
            r_drv_go   <= w_go;
            r_drv_sel  <= w_sel;
            r_drv_data <= w_data;
            r_a_ready  <= (r_state == S_IDLE) && w_tick && bus.a_valid;
            r_b_ready  <= (r_state == S_IDLE) && w_tick && bus.b_valid;
            if (r_state == S_CAP) begin
                r_shadow_a <= w_cap_a;
                r_shadow_b <= w_cap_b;
            end
            // Sets win over a simultaneous clear.
            r_underrun <= (clear_flags ? 2'b00 : r_underrun) | w_ur_set;
            r_overrun  <= (clear_flags ? 1'b0 : r_overrun) | (w_tick && (r_state != S_IDLE));
        end
    end

    assign bus.drv_go   = r_drv_go;
    assign bus.drv_sel  = r_drv_sel;
    assign bus.drv_data = r_drv_data;
    assign bus.a_ready  = r_a_ready;
    assign bus.b_ready  = r_b_ready;
    assign busy         = (r_state != S_IDLE);
    assign underrun     = r_underrun;
    assign overrun      = r_overrun;
endmodule

// File: tb/tb_dac_frame_scheduler.sv
// Directed bench for dac_frame_scheduler at CLK_DIV=16 with a behavioural SPI driver model.
module tb_dac_frame_scheduler;
    localparam int CLK_DIV = 16;
`ifdef DAC_HOLD_LAST_EN
    localparam bit HOLD = 1'b1;
`else
    localparam bit HOLD = 1'b0;
`endif

    typedef struct {
        logic        a_v;
        logic [11:0] a_d;
        logic        b_v;
        logic [11:0] b_d;
        logic [11:0] exp_a;
        logic [11:0] exp_b;
        logic [1:0]  exp_ur;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic       clear_flags;
    logic       busy;
    logic [1:0] underrun;
    logic       overrun;

    dac_frame_if #(.DATA_W(12)) bus ();

    dac_frame_scheduler #(.CLK_DIV(CLK_DIV), .DATA_W(12)) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .clear_flags (clear_flags),
        .bus         (bus),
        .busy        (busy),
        .underrun    (underrun),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    // Driver model: drops ready after each go, holds it low m_busy cycles.
    logic m_rdy;
    logic hold;
    int   m_cnt;
    int   m_busy;
    assign bus.drv_ready = m_rdy & ~hold;

    always @(negedge clk or posedge rst) begin
        if (rst) begin
            m_rdy = 1'b1;
            m_cnt = 0;
        end else if (bus.drv_go) begin
            m_rdy = 1'b0;
            m_cnt = m_busy;
        end else if (m_cnt > 0) begin
            m_cnt = m_cnt - 1;
            if (m_cnt == 0) m_rdy = 1'b1;
        end
    end

    int          cyc = 0;
    int          go_cyc[$];
    logic        go_sel[$];
    logic [11:0] go_dat[$];
    int          a_rdy_n = 0;
    int          b_rdy_n = 0;
    int          bad_go = 0;

    always @(posedge clk) begin
        #1;
        cyc = cyc + 1;
        if (bus.drv_go) begin
            go_cyc.push_back(cyc);
            go_sel.push_back(bus.drv_sel);
            go_dat.push_back(bus.drv_data);
            if (!bus.drv_ready) bad_go = bad_go + 1;
        end
        if (bus.a_ready) a_rdy_n = a_rdy_n + 1;
        if (bus.b_ready) b_rdy_n = b_rdy_n + 1;
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    function automatic int go_at(input int i);
        return (i < go_cyc.size()) ? go_cyc[i] : -1;
    endfunction
    function automatic logic go_sel_at(input int i);
        return (i < go_sel.size()) ? go_sel[i] : 1'bx;
    endfunction
    function automatic logic [11:0] go_dat_at(input int i);
        return (i < go_dat.size()) ? go_dat[i] : 12'hxxx;
    endfunction

    task automatic wait_go(input int n, input int budget);
        int k = 0;
        while (go_cyc.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (go_cyc.size() < n) begin
            n_tests++;
            n_fail++;
            $display("FAIL go_timeout: got %0d drv_go pulses, want %0d", go_cyc.size(), n);
        end
    endtask

    task automatic wait_idle();
        int k = 0;
        while (busy && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (busy) begin
            n_tests++;
            n_fail++;
            $display("FAIL idle_timeout: busy still 1 after 200 cycles");
        end
    endtask

    task automatic wait_cyc(input int target);
        int k = 0;
        while (cyc < target && k < 200) begin
            @(negedge clk);
            k++;
        end
    endtask

    task automatic clear_pulse();
        clear_flags = 1'b1;
        @(negedge clk);
        clear_flags = 1'b0;
    endtask

    vec_t vecs[6];

    initial begin
        int base, ra, rb, g, r, k;

        vecs[0] = '{1'b1, 12'h123, 1'b1, 12'hABC, 12'h123, 12'hABC, 2'b00};
        vecs[1] = '{1'b1, 12'h400, 1'b0, 12'h000, 12'h400, (HOLD ? 12'hABC : 12'h800), 2'b10};
        vecs[2] = '{1'b0, 12'h000, 1'b1, 12'h555, (HOLD ? 12'h400 : 12'h800), 12'h555, 2'b01};
        vecs[3] = '{1'b0, 12'h000, 1'b0, 12'h000, (HOLD ? 12'h400 : 12'h800),
                    (HOLD ? 12'h555 : 12'h800), 2'b11};
        vecs[4] = '{1'b1, 12'hFFF, 1'b1, 12'h000, 12'hFFF, 12'h000, 2'b00};
        vecs[5] = '{1'b1, 12'h001, 1'b1, 12'h7FF, 12'h001, 12'h7FF, 2'b00};

        rst = 1'b1; enable = 1'b0; clear_flags = 1'b0; hold = 1'b0; m_busy = 3;
        bus.a_valid = 1'b0; bus.a_data = '0; bus.b_valid = 1'b0; bus.b_data = '0;
        repeat (3) @(negedge clk);
        chk("rst_drv_go",   32'(bus.drv_go), 32'd0);
        chk("rst_drv_sel",  32'(bus.drv_sel), 32'd0);
        chk("rst_drv_data", 32'(bus.drv_data), 32'd0);
        chk("rst_a_ready",  32'(bus.a_ready), 32'd0);
        chk("rst_b_ready",  32'(bus.b_ready), 32'd0);
        chk("rst_busy",     32'(busy), 32'd0);
        chk("rst_underrun", 32'(underrun), 32'd0);
        chk("rst_overrun",  32'(overrun), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Table: one frame per vector, back to back at the sample rate.
        for (int i = 0; i < 6; i++) begin
            bus.a_valid = vecs[i].a_v; bus.a_data = vecs[i].a_d;
            bus.b_valid = vecs[i].b_v; bus.b_data = vecs[i].b_d;
            if (i == 0) begin
                enable = 1'b1;
                g = cyc;
            end
            base = go_cyc.size(); ra = a_rdy_n; rb = b_rdy_n;
            wait_go(base + 2, 80);
            if (i == 0) chk("first_go_latency", 32'(go_at(base) - g), 32'(CLK_DIV + 2));
            else        chk($sformatf("v%0d_period", i), 32'(go_at(base) - go_at(base - 2)), 32'(CLK_DIV));
            chk($sformatf("v%0d_sel_a", i),  32'(go_sel_at(base)), 32'd0);
            chk($sformatf("v%0d_data_a", i), 32'(go_dat_at(base)), 32'(vecs[i].exp_a));
            chk($sformatf("v%0d_sel_b", i),  32'(go_sel_at(base + 1)), 32'd1);
            chk($sformatf("v%0d_data_b", i), 32'(go_dat_at(base + 1)), 32'(vecs[i].exp_b));
            chk($sformatf("v%0d_a_to_b", i), 32'(go_at(base + 1) - go_at(base)), 32'd5);
            wait_idle();
            chk($sformatf("v%0d_a_ready_n", i), 32'(a_rdy_n - ra), 32'(vecs[i].a_v));
            chk($sformatf("v%0d_b_ready_n", i), 32'(b_rdy_n - rb), 32'(vecs[i].b_v));
            chk($sformatf("v%0d_underrun", i), 32'(underrun), 32'(vecs[i].exp_ur));
            chk($sformatf("v%0d_overrun", i), 32'(overrun), 32'd0);
            clear_pulse();
            chk($sformatf("v%0d_cleared", i), 32'(underrun), 32'd0);
        end

        // Frame longer than the period: tick dropped, clear in the same cycle loses to the set.
        m_busy = 10;
        base = go_cyc.size();
        wait_go(base + 1, 40);
        g = go_at(base);
        wait_cyc(g + CLK_DIV - 2);
        clear_pulse();
        chk("ovr_set_wins", 32'(overrun), 32'd1);
        wait_go(base + 3, 80);
        chk("ovr_period", 32'(go_at(base + 2) - g), 32'(2 * CLK_DIV));
        wait_idle();
        m_busy = 3;
        chk("ovr_sticky", 32'(overrun), 32'd1);
        clear_pulse();
        chk("ovr_cleared", 32'(overrun), 32'd0);

        // Driver stalled at GO_A for 50 cycles.
        wait_idle();
        hold = 1'b1;
        base = go_cyc.size();
        k = 0;
        while (!busy && k < 40) begin
            @(negedge clk);
            k++;
        end
        repeat (50) @(negedge clk);
        chk("hold_no_go", 32'(go_cyc.size() - base), 32'd0);
        chk("hold_busy", 32'(busy), 32'd1);
        hold = 1'b0;
        r = cyc;
        wait_go(base + 1, 10);
        chk("hold_go_cycle", 32'(go_at(base) - r), 32'd1);
        chk("hold_go_sel", 32'(go_sel_at(base)), 32'd0);
        wait_go(base + 2, 40);
        wait_idle();
        clear_pulse();

        // Asynchronous reset inside WAIT_A (the go cycle itself).
        base = go_cyc.size();
        wait_go(base + 1, 40);
        #1 rst = 1'b1;
        #1;
        chk("mid_rst_go",   32'(bus.drv_go), 32'd0);
        chk("mid_rst_sel",  32'(bus.drv_sel), 32'd0);
        chk("mid_rst_data", 32'(bus.drv_data), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_ur",   32'(underrun), 32'd0);
        chk("mid_rst_ov",   32'(overrun), 32'd0);
        #1 rst = 1'b0;
        r = cyc;
        base = go_cyc.size();
        wait_go(base + 1, 40);
        chk("post_rst_go_cycle", 32'(go_at(base) - r), 32'(CLK_DIV + 2));

        // enable dropped during CAP: frame finishes, then everything stops.
        k = a_rdy_n;
        g = 0;
        while (a_rdy_n == k && g < 100) begin
            @(negedge clk);
            g++;
        end
        chk("cap_seen", 32'(a_rdy_n - k), 32'd1);
        enable = 1'b0;
        base = go_cyc.size();
        wait_go(base + 2, 60);
        chk("en_drop_sel_a",  32'(go_sel_at(base)), 32'd0);
        chk("en_drop_data_a", 32'(go_dat_at(base)), 32'h001);
        chk("en_drop_sel_b",  32'(go_sel_at(base + 1)), 32'd1);
        chk("en_drop_data_b", 32'(go_dat_at(base + 1)), 32'h7FF);
        repeat (40) @(negedge clk);
        chk("en_drop_no_more_go", 32'(go_cyc.size() - base), 32'd2);
        chk("en_drop_cnt_zero", 32'(dut.r_cnt), 32'd0);
        chk("en_drop_idle", 32'(busy), 32'd0);
        chk("go_while_not_ready", 32'(bad_go), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end
endmodule
